// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci checker: sequence length, term table
// and the HUNT/LOCK state encoding. Also used by the Fib generator bench.
package fib_pkg;

  localparam int FIB_LEN = 10;

  // Term at index i lives in entry [i].
  localparam logic [FIB_LEN-1:0][5:0] FIB_TABLE = {
    6'd34, 6'd21, 6'd13, 6'd8, 6'd5, 6'd3, 6'd2, 6'd1, 6'd1, 6'd0
  };

  localparam logic [3:0] LAST_IDX = 4'(FIB_LEN - 1);

  typedef logic state_t;
  localparam state_t ST_HUNT = 1'b0;
  localparam state_t ST_LOCK = 1'b1;

endpackage

// File: rtl/fib_rom.sv
// Combinational term lookup: 4-bit index to 6-bit Fibonacci term.
// Indices past the end of the table return 0.
module fib_rom
  import fib_pkg::*;
(
  input  logic [3:0] idx,
  output logic [5:0] term
);

  // Compare against every table slot so out-of-range indices fall through to 0.
  always_comb begin
    term = '0;
    for (int i = 0; i < FIB_LEN; i++)
      if (idx == 4'(i)) term = FIB_TABLE[i];
  end

endmodule

// File: rtl/fib_checker.sv
// Fibonacci sequence checker. Hunts for a 0, then tracks the cyclic sequence
// 0,1,1,2,...,34 and flags match / mismatch / end-of-sequence per sample.
// Optional feature: define FIB_CHECK_ERRCNT_EN to build the saturating
// mismatch counter; otherwise err_count is tied to 0.
module fib_checker
  import fib_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       ain,
  input  logic             ain_valid,
  output logic             locked,
  output logic             match,
  output logic             mismatch,
  output logic             seq_done,
  output logic [3:0]       exp_index,
  output logic [ERR_W-1:0] err_count
);

  state_t     state;
  logic [5:0] exp_term;

  fib_rom u_rom (
    .idx  (exp_index),
    .term (exp_term)
  );

  assign locked = (state == ST_LOCK);

  // Sequence tracker: state, expected index and the one-cycle result pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_HUNT;
      exp_index <= '0;
      match     <= 1'b0;
      mismatch  <= 1'b0;
      seq_done  <= 1'b0;
    end else begin
      match    <= 1'b0;
      mismatch <= 1'b0;
      seq_done <= 1'b0;
      if (ain_valid) begin
        if (state == ST_HUNT) begin
          if (ain == 6'd0) begin
            state     <= ST_LOCK;
            exp_index <= 4'd1;
            match     <= 1'b1;
          end
        end else if (ain == exp_term) begin
          match     <= 1'b1;
          seq_done  <= (exp_index == LAST_IDX);
          exp_index <= (exp_index == LAST_IDX) ? 4'd0 : exp_index + 4'd1;
        end else begin
          mismatch <= 1'b1;
          // A 0 is itself a valid sequence start, so relock on it directly.
          if (ain == 6'd0) begin
            exp_index <= 4'd1;
          end else begin
            state     <= ST_HUNT;
            exp_index <= '0;
          end
        end
      end
    end
  end

`ifdef FIB_CHECK_ERRCNT_EN
  logic miss_event;
  assign miss_event = ain_valid && (state == ST_LOCK) && (ain != exp_term);

  // Saturating mismatch counter; holds at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      err_count <= '0;
    else if (miss_event && !(&err_count))
      err_count <= err_count + ERR_W'(1);
  end
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_fib_checker.sv
// Scoreboard bench for fib_checker: a behavioural model pushes the expected
// post-edge outputs when each sample is driven; they are popped and compared
// after the edge. Two instances share stimulus: default ERR_W and ERR_W=2.
module tb_fib_checker;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] ain = '0;
  logic       ain_valid = 1'b0;

  logic       locked_a, match_a, mismatch_a, seq_done_a;
  logic [3:0] exp_index_a;
  logic [7:0] err_count_a;
  logic       locked_b, match_b, mismatch_b, seq_done_b;
  logic [3:0] exp_index_b;
  logic [1:0] err_count_b;

  always #5 clock = ~clock;

  fib_checker u_dut (
    .clock(clock), .reset(reset), .ain(ain), .ain_valid(ain_valid),
    .locked(locked_a), .match(match_a), .mismatch(mismatch_a),
    .seq_done(seq_done_a), .exp_index(exp_index_a), .err_count(err_count_a)
  );

  fib_checker #(.ERR_W(2)) u_dut2 (
    .clock(clock), .reset(reset), .ain(ain), .ain_valid(ain_valid),
    .locked(locked_b), .match(match_b), .mismatch(mismatch_b),
    .seq_done(seq_done_b), .exp_index(exp_index_b), .err_count(err_count_b)
  );

  typedef struct {
    logic       match;
    logic       mismatch;
    logic       seq_done;
    logic       locked;
    logic [3:0] idx;
    logic [7:0] err8;
    logic [1:0] err2;
  } exp_t;

  exp_t  sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  string cur     = "";

  // Reference model state
  int ref_tab[10] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
  bit m_lock = 0;
  int m_idx  = 0;
  int m_err8 = 0;
  int m_err2 = 0;

  task automatic model_clear();
    m_lock = 0; m_idx = 0; m_err8 = 0; m_err2 = 0;
  endtask

  // Drive one sample, predict, clock it, then pop and compare both instances.
  task automatic step(input logic v, input logic [5:0] a);
    exp_t e, g;
    @(negedge clock);
    ain_valid = v;
    ain = a;
    e.match = 0; e.mismatch = 0; e.seq_done = 0;
    if (v) begin
      if (!m_lock) begin
        if (a == 0) begin m_lock = 1; m_idx = 1; e.match = 1; end
      end else if (int'(a) == ref_tab[m_idx]) begin
        e.match = 1;
        e.seq_done = (m_idx == 9);
        m_idx = (m_idx + 1) % 10;
      end else begin
        e.mismatch = 1;
        if (m_err8 < 255) m_err8++;
        if (m_err2 < 3) m_err2++;
        if (a == 0) m_idx = 1;
        else begin m_lock = 0; m_idx = 0; end
      end
    end
    e.locked = m_lock;
    e.idx = 4'(m_idx);
`ifdef FIB_CHECK_ERRCNT_EN
    e.err8 = 8'(m_err8);
    e.err2 = 2'(m_err2);
`else
    e.err8 = 8'd0;
    e.err2 = 2'd0;
`endif
    sb.push_back(e);
    @(posedge clock);
    #1;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s scoreboard empty", cur);
    end else begin
      g = sb.pop_front();
      if ({match_a, mismatch_a, seq_done_a, locked_a} !== {g.match, g.mismatch, g.seq_done, g.locked}) begin
        n_fail++;
        $display("FAIL %s flags got m/mm/done/lk=%b%b%b%b exp %b%b%b%b ain=%0d",
                 cur, match_a, mismatch_a, seq_done_a, locked_a,
                 g.match, g.mismatch, g.seq_done, g.locked, a);
      end
      n_tests++;
      if (exp_index_a !== g.idx) begin
        n_fail++;
        $display("FAIL %s exp_index got %0d exp %0d", cur, exp_index_a, g.idx);
      end
      n_tests++;
      if (err_count_a !== g.err8) begin
        n_fail++;
        $display("FAIL %s err_count got %0d exp %0d", cur, err_count_a, g.err8);
      end
      n_tests++;
      if ({match_b, mismatch_b, seq_done_b, locked_b, exp_index_b, err_count_b} !==
          {g.match, g.mismatch, g.seq_done, g.locked, g.idx, g.err2}) begin
        n_fail++;
        $display("FAIL %s errw2 got %b%b%b%b idx=%0d err=%0d exp %b%b%b%b idx=%0d err=%0d",
                 cur, match_b, mismatch_b, seq_done_b, locked_b, exp_index_b, err_count_b,
                 g.match, g.mismatch, g.seq_done, g.locked, g.idx, g.err2);
      end
    end
  endtask

  // All outputs of both instances must be zero.
  task automatic check_zero(input string tag);
    n_tests++;
    if ({locked_a, match_a, mismatch_a, seq_done_a, exp_index_a, err_count_a,
         locked_b, match_b, mismatch_b, seq_done_b, exp_index_b, err_count_b} !== '0) begin
      n_fail++;
      $display("FAIL %s outputs not zero: lk=%b m=%b mm=%b d=%b idx=%0d err=%0d / err2=%0d",
               tag, locked_a, match_a, mismatch_a, seq_done_a, exp_index_a, err_count_a, err_count_b);
    end
  endtask

  // Reset held across an edge with ain_valid=1, ain=0: reset must win.
  task automatic apply_reset();
    @(negedge clock);
    reset = 1; ain_valid = 1; ain = 6'd0;
    @(posedge clock);
    #1;
    check_zero({cur, "/reset"});
    @(negedge clock);
    reset = 0; ain_valid = 0;
    model_clear();
  endtask

  task automatic test_reset();
    cur = "reset";
    #1;
    check_zero("reset_initial");
    apply_reset();
    step(0, 6'd0);
  endtask

  task automatic test_full_sequence();
    cur = "full_seq";
    apply_reset();
    step(1, 6'd7);   // non-zero in HUNT: ignored
    for (int i = 0; i < 10; i++) step(1, 6'(ref_tab[i]));
    for (int i = 0; i < 3; i++) step(1, 6'(ref_tab[i]));  // wraps
  endtask

  task automatic test_mismatch_nonzero();
    cur = "mismatch_nz";
    apply_reset();
    for (int i = 0; i < 4; i++) step(1, 6'(ref_tab[i]));
    step(1, 6'd7);   // exp_index 4 -> HUNT
    step(1, 6'd0);   // relock
    step(1, 6'd1);
  endtask

  task automatic test_resync();
    cur = "resync";
    apply_reset();
    for (int i = 0; i < 6; i++) step(1, 6'(ref_tab[i]));
    step(1, 6'd0);   // exp_index 6, ain 0 -> stay LOCK, idx 1
    step(1, 6'd1);
    step(1, 6'd1);
    step(1, 6'd2);
  endtask

  task automatic test_saturation();
    cur = "saturate";
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 6'd0);
      step(1, 6'd9);
    end
    step(1, 6'd0);
    step(1, 6'd63);
  endtask

  task automatic test_hold_and_reset();
    cur = "hold_reset";
    apply_reset();
    for (int i = 0; i < 3; i++) step(1, 6'(ref_tab[i]));
    for (int i = 0; i < 3; i++) step(0, 6'd5);
    step(1, 6'd2);
    step(1, 6'd3);   // exp_index now 5
    @(negedge clock);
    reset = 1;
    #1;
    check_zero("hold_reset/async");
    @(negedge clock);
    reset = 0;
    model_clear();
    step(1, 6'd5);
    step(1, 6'd0);
    step(1, 6'd1);
  endtask

  task automatic test_back_to_back();
    int r;
    cur = "random";
    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) step(1, 6'(ref_tab[m_idx]));
      else if (r < 7) step(0, 6'($urandom_range(0, 63)));
      else if (r < 8) step(1, 6'd0);
      else step(1, 6'($urandom_range(0, 63)));
    end
  endtask

  initial begin
    test_reset();
    test_full_sequence();
    test_mismatch_nonzero();
    test_resync();
    test_saturation();
    test_hold_and_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
